npu_tile_loader: RTL and testbench
==================================

// Module: npu_tile_loader
// PURPOSE
//  Upstream feeder of the 10x10 weight-stationary systolic array. On request, fetches
//  one NxN tile of signed 16-bit activations from a synchronous-read image memory
//  (row-major, row stride IMG_W), holds it stable on `tile`, pulses `sa_start`,
//  waits for the array's `done`, then reports completion to the sequencer.
// PARAMETERS
//  N      10   tile edge; must match the systolic array dimension
//  DW     16   data width of memory words and tile elements (signed)
//  AW     16   memory address width
//  IMG_W  64   image row stride in words
// PORTS
//  clk           in   1        clock
//  rst           in   1        asynchronous reset, active-high
//  req           in   1        start tile fetch; sampled only in IDLE
//  base_addr     in   AW       address of tile element [0][0]; latched on accepted req
//  busy          out  1        high in every state except IDLE
//  mem_rd_en     out  1        memory read strobe
//  mem_addr      out  AW       memory read address
//  mem_rd_data   in   DW       read data, valid exactly 1 cycle after mem_rd_en
//  tile          out  DW[N][N] signed tile; drives systolic array A[N][N]
//  sa_start      out  1        one-cycle start pulse to the systolic array
//  sa_done       in   1        systolic array done (level)
//  tile_done     out  1        one-cycle pulse: array finished with this tile
// BEHAVIOUR
//  Reset (async, any state, incl. mid-fetch): state=IDLE; busy, mem_rd_en, sa_start,
//   tile_done=0; mem_addr=0; tile all zeros; row/col counters=0; done_seen_low=0.
//  FSM: IDLE -> FETCH -> DRAIN -> START -> WAIT_SA -> FINISH -> IDLE.
//  IDLE: req=1 -> latch base_addr, r=c=0, go FETCH. req ignored in any other state.
//  FETCH: one read per cycle, N*N cycles, row-major: mem_rd_en=1,
//   mem_addr = base + r*IMG_W + c (mod 2^AW, wrap silently). c wraps N-1->0 and
//   increments r. Write-back pipeline: data returned in cycle k+1 is written to
//   tile[r_k][c_k] (address/index pair delayed one cycle). After read (N-1,N-1): DRAIN.
//  DRAIN: mem_rd_en=0; capture last word into tile[N-1][N-1]; go START.
//  START: sa_start=1 for exactly this cycle; clear done_seen_low; go WAIT_SA.
//  WAIT_SA: tile held constant. Set done_seen_low when sa_done=0. Advance to FINISH
//   on first cycle with sa_done=1 AND done_seen_low=1 (rejects stale/stuck done
//   level left from a previous run). No timeout; a stuck-high done hangs here.
//  FINISH: tile_done=1 for one cycle; go IDLE. tile keeps last contents until next fetch.
//  Latency: req accepted at edge t -> first mem_rd_en at t+1; sa_start at t+N*N+2.
//  tile elements not yet refetched keep old values during FETCH (no clear).
//  mem_rd_data is never sign-adjusted; stored bit-exact.
//  Address arithmetic in AW bits; r*IMG_W computed by incremental row-base adder
//   (row_base += IMG_W on row wrap), no multiplier.
// TESTING
//  1 Reset: assert rst mid-FETCH (cycle 37) -> same cycle busy=0, mem_rd_en=0,
//    tile all 0; after release, req restarts cleanly from base_addr.
//  2 Ramp: mem[a]=a, base=0, IMG_W=64 -> tile[r][c]=64r+c; sa_start exactly
//    102 cycles after req edge; mem_rd_en high exactly 100 cycles.
//  3 Signed/wrap: base=16'hFFF0, mem holds -1..-32768 pattern -> addresses wrap
//    to 0x0000..; tile matches bit-exact incl. negative values.
//  4 Handshake: sa_done held 1 before start -> loader stays in WAIT_SA until done
//    drops and rises again; tile_done single pulse 1 cycle after that rise.
//  5 req while busy (every FETCH cycle) -> ignored, base_addr unchanged; req held
//    high through FINISH -> second fetch begins the cycle after returning to IDLE.
//  6 End-to-end with systolic_array: loaded tile -> array results match golden model.

Source files
------------

// File: rtl/npu_tile_loader.sv
// npu_tile_loader: fetches one NxN tile of signed activations from a
// synchronous-read image memory, holds it on `tile`, starts the systolic
// array, waits for a fresh `sa_done` rising level and reports `tile_done`.
module npu_tile_loader #(
   parameter int N     = 10,
   parameter int DW    = 16,
   parameter int AW    = 16,
   parameter int IMG_W = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req,
   input  logic [AW-1:0]                 base_addr,
   output logic                          busy,
   output logic                          mem_rd_en,
   output logic [AW-1:0]                 mem_addr,
   input  logic [DW-1:0]                 mem_rd_data,
   output logic [N-1:0][N-1:0][DW-1:0]   tile,
   output logic                          sa_start,
   input  logic                          sa_done,
   output logic                          tile_done
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_START,
      S_WAIT_SA,
      S_FINISH
   } state_t;

   state_t          state_reg;
   state_t          state_next;

   logic [AW-1:0]   base_reg;
   logic [AW-1:0]   row_base_reg;
   logic [CW-1:0]   r_reg;
   logic [CW-1:0]   c_reg;
   logic [CW-1:0]   wr_r_reg;
   logic [CW-1:0]   wr_c_reg;
   logic            wr_valid_reg;
   logic            done_seen_low_reg;
   logic            last_read;

   assign last_read = (r_reg == CW'(N-1)) && (c_reg == CW'(N-1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; a done level only counts after it has been seen low
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:    if (req) state_next = S_FETCH;
         S_FETCH:   if (last_read) state_next = S_DRAIN;
         S_DRAIN:   state_next = S_START;
         S_START:   state_next = S_WAIT_SA;
         S_WAIT_SA: if (sa_done && done_seen_low_reg) state_next = S_FINISH;
         S_FINISH:  state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   // Outputs decoded from the current state
   always_comb begin
      busy      = (state_reg != S_IDLE);
      mem_rd_en = (state_reg == S_FETCH);
      mem_addr  = '0;
      if (state_reg == S_FETCH) begin
         mem_addr = base_reg + row_base_reg + AW'(c_reg);
      end
      sa_start  = (state_reg == S_START);
      tile_done = (state_reg == S_FINISH);
   end

   // Base latch and row/column walk; row offset grows by the stride on each row wrap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_reg     <= '0;
         row_base_reg <= '0;
         r_reg        <= '0;
         c_reg        <= '0;
      end else begin
         if (state_reg == S_IDLE) begin
            if (req) begin
               base_reg     <= base_addr;
               row_base_reg <= '0;
               r_reg        <= '0;
               c_reg        <= '0;
            end
         end else if (state_reg == S_FETCH) begin
            if (c_reg == CW'(N-1)) begin
               c_reg        <= '0;
               r_reg        <= r_reg + 1'b1;
               row_base_reg <= row_base_reg + AW'(IMG_W);
            end else begin
               c_reg <= c_reg + 1'b1;
            end
         end
      end
   end

   // Delay the tile index by one cycle to line up with the memory read latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_valid_reg <= 1'b0;
         wr_r_reg     <= '0;
         wr_c_reg     <= '0;
      end else begin
         wr_valid_reg <= (state_reg == S_FETCH);
         wr_r_reg     <= r_reg;
         wr_c_reg     <= c_reg;
      end
   end

   // Tile storage: returned word written bit-exact; untouched elements keep old values
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tile <= '0;
      end else if (wr_valid_reg) begin
         tile[wr_r_reg][wr_c_reg] <= mem_rd_data;
      end
   end

   // Track that sa_done has been low since this run's start pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_seen_low_reg <= 1'b0;
      end else if (state_reg == S_START) begin
         done_seen_low_reg <= 1'b0;
      end else if ((state_reg == S_WAIT_SA) && !sa_done) begin
         done_seen_low_reg <= 1'b1;
      end
   end

endmodule

// File: tb/tb_npu_tile_loader.sv
// Directed bench for npu_tile_loader: scoreboard of expected addresses and
// tile contents, latency checks and sa_done handshake checks.
module tb_npu_tile_loader;

   localparam int N     = 10;
   localparam int DW    = 16;
   localparam int AW    = 16;
   localparam int IMG_W = 64;

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        req;
   logic [AW-1:0]               base_addr;
   logic                        busy;
   logic                        mem_rd_en;
   logic [AW-1:0]               mem_addr;
   logic [DW-1:0]               mem_rd_data;
   logic [N-1:0][N-1:0][DW-1:0] tile;
   logic                        sa_start;
   logic                        sa_done;
   logic                        tile_done;

   npu_tile_loader #(.N(N), .DW(DW), .AW(AW), .IMG_W(IMG_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .base_addr   (base_addr),
      .busy        (busy),
      .mem_rd_en   (mem_rd_en),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .tile        (tile),
      .sa_start    (sa_start),
      .sa_done     (sa_done),
      .tile_done   (tile_done)
   );

   always #5 clk = ~clk;

   // Image memory model: synchronous read, one cycle latency
   logic [DW-1:0] mem [0:65535];
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_addr];
   end

   int n_cmp = 0;
   int n_bad = 0;

   logic [AW-1:0] addr_q[$];
   logic [DW-1:0] data_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_tile(input logic [AW-1:0] base);
      logic [AW-1:0] a;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            a = base + AW'(r * IMG_W + c);
            addr_q.push_back(a);
            data_q.push_back(mem[a]);
         end
      end
   endtask

   // mode 0: done low then rises; mode 1: done stuck high, drops, rises again
   task automatic run_tile(input logic [AW-1:0] base, input int mode,
                           input bit keep_req, input logic [AW-1:0] next_base);
      int            start_n = 0;
      int            done_n  = 0;
      int            rd_cnt  = 0;
      int            rise_n;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      push_tile(base);
      req       = 1'b1;
      base_addr = base;
      if (mode == 1) sa_done = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int n = 1; n <= 400 && done_n == 0; n++) begin
         if (keep_req) begin
            req       = 1'b1;
            base_addr = base ^ 16'h5A5A ^ AW'(n);
         end else begin
            req = 1'b0;
         end
         if (n == 1) check("busy_after_req", busy, 1);
         if (mem_rd_en) begin
            rd_cnt++;
            if (addr_q.size() == 0) check("addr_q_underflow", rd_cnt, 0);
            else begin
               ea = addr_q.pop_front();
               check("mem_addr", mem_addr, ea);
            end
         end
         if (sa_start) begin
            if (start_n == 0) start_n = n;
            else check("sa_start_repeat", n, start_n);
         end
         if (tile_done) done_n = n;
         if (start_n != 0) begin
            if (mode == 0) sa_done = (n >= start_n + 4);
            else           sa_done = !(n == start_n + 5 || n == start_n + 6);
         end
         if (done_n == 0) @(negedge clk);
      end
      rise_n = start_n + ((mode == 0) ? 4 : 7);
      check("rd_count", rd_cnt, 100);
      check("sa_start_latency", start_n, 102);
      check("tile_done_latency", done_n, rise_n + 1);
      check("addr_q_empty", addr_q.size(), 0);
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            if (data_q.size() != 0) begin
               ed = data_q.pop_front();
               check($sformatf("tile[%0d][%0d]", r, c), tile[r][c], ed);
            end
         end
      end
      sa_done = 1'b0;
      if (keep_req) begin
         req       = 1'b1;
         base_addr = next_base;
      end else begin
         req = 1'b0;
      end
      @(negedge clk);
      check("tile_done_pulse", tile_done, 0);
      check("busy_idle", busy, 0);
      $display("tile base=%h mode=%0d keep_req=%0d rd=%0d sa_start@%0d tile_done@%0d",
               base, mode, keep_req, rd_cnt, start_n, done_n);
   endtask

   initial begin
      rst       = 1'b1;
      req       = 1'b0;
      sa_done   = 1'b0;
      base_addr = '0;
      for (int a = 0; a < 65536; a++) mem[a] = 16'(a);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_mem_rd_en", mem_rd_en, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_sa_start", sa_start, 0);
      check("rst_tile_done", tile_done, 0);
      check("rst_tile_zero", 32'(tile == '0), 1);
      rst = 1'b0;
      @(negedge clk);

      // Ramp image, base 0
      run_tile(16'h0000, 0, 1'b0, 16'h0000);

      // Reset in the middle of a fetch, then restart from the same base
      req       = 1'b1;
      base_addr = 16'h0100;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      repeat (36) @(negedge clk);
      check("midfetch_busy", busy, 1);
      #1 rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_mem_rd_en", mem_rd_en, 0);
      check("midrst_mem_addr", mem_addr, 0);
      check("midrst_tile_zero", 32'(tile == '0), 1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      $display("reset asserted mid-fetch, tile cleared");
      @(negedge clk);
      run_tile(16'h0100, 0, 1'b0, 16'h0000);

      // Negative data and address wrap past 0xFFFF
      for (int a = 0; a < 65536; a++) mem[a] = ~16'(a);
      run_tile(16'hFFF0, 0, 1'b0, 16'h0000);

      // Stale done level must be rejected until it drops and rises again
      run_tile(16'h0234, 1, 1'b0, 16'h0000);

      // req held while busy is ignored; held through FINISH restarts immediately
      run_tile(16'h0400, 0, 1'b1, 16'h0800);
      run_tile(16'h0800, 0, 1'b0, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
